kbd_mmio_fifo: RTL and testbench

- Memory-mapped keyboard receive peripheral on the CPU data bus, downstream of the uniciclo datapath.
- Consumes the datapath's DwReadEnable/DwWriteEnable/DwByteEnable/DwAddress/DwWriteData and returns read data plus a hit flag to the top-level bus mux.
- Buffers bytes from the keyboard decoder in a FIFO.
- Exposes a control/status register and a data register.
- Raises an interrupt line that feeds iPendingInterrupt.

---
 rtl/kbd_mmio_fifo.sv | 136 +++++++++++++
 tb/tb_kbd_mmio_fifo.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/kbd_mmio_fifo.sv
// ---------------------------------------------------------------------------
// kbd_mmio_fifo
//   Memory-mapped keyboard receive peripheral. Bytes from the keyboard decoder
//   are queued in a FIFO; the CPU sees a control/status register (CTRL) at
//   BASE_ADDR and a data register (DATA) at BASE_ADDR+4.
//
//   CTRL : bit0 READY (FIFO not empty), bit1 IE (RW), bit2 OVF (sticky, W1C),
//          bits[8+AW:8] count (RO). Byte lane 0 must be enabled for a write.
//   DATA : read returns the FIFO head and pops it; returns 0 when empty.
//          Writes are ignored.
//
// Ports
//   iCLK, iRST          clock, asynchronous active-low reset
//   iKeyData, iKeyValid received byte and its single-cycle push strobe
//   iReadEnable, iWriteEnable, iByteEnable, iAddress, iWriteData
//                       data-bus request from the datapath
//   oReadData, oHit     combinational read data and address-hit flag
//   oIRQ                registered interrupt request (IE & FIFO not empty)
// ---------------------------------------------------------------------------
module kbd_mmio_fifo #(
  parameter logic [31:0] BASE_ADDR = 32'hFF20_0000,
  parameter int          DEPTH     = 16,
  parameter int          AW        = 4
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic [7:0]  iKeyData,
  input  logic        iKeyValid,
  input  logic        iReadEnable,
  input  logic        iWriteEnable,
  input  logic [3:0]  iByteEnable,
  input  logic [31:0] iAddress,
  input  logic [31:0] iWriteData,
  output logic [31:0] oReadData,
  output logic        oHit,
  output logic        oIRQ
);

  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   count;
  logic [AW:0]   count_next;
  logic          ie;
  logic          ie_next;
  logic          ovf;
  logic          ovf_next;

  logic          sel_ctrl;
  logic          sel_data;
  logic          empty;
  logic          full;
  logic          pop;
  logic          push_ok;
  logic          overflow;
  logic          ctrl_wr;
  logic [31:0]   ctrl_val;
  logic [31:0]   data_val;

  // Only IE (bit1), OVF-clear (bit2) and byte lane 0 carry meaning.
  logic          unused_bits;
  assign unused_bits = ^{iWriteData[31:3], iWriteData[0], iByteEnable[3:1]};

  assign sel_ctrl = (iAddress == BASE_ADDR);
  assign sel_data = (iAddress == BASE_ADDR + 32'd4);
  assign oHit     = sel_ctrl | sel_data;

  assign empty    = (count == '0);
  assign full     = (count == FULL_COUNT);

  // A pop frees a slot in the same edge, so a full FIFO still accepts a
  // simultaneous push without flagging overflow.
  assign pop      = iReadEnable & sel_data & ~empty;
  assign push_ok  = iKeyValid & (~full | pop);
  assign overflow = iKeyValid & full & ~pop;
  assign ctrl_wr  = iWriteEnable & sel_ctrl & iByteEnable[0];

  always_comb begin
    ctrl_val            = '0;
    ctrl_val[0]         = ~empty;
    ctrl_val[1]         = ie;
    ctrl_val[2]         = ovf;
    ctrl_val[8+AW:8]    = count;
  end

  assign data_val  = empty ? 32'h0 : {24'h0, mem[rd_ptr]};

  always_comb begin
    oReadData = 32'h0;
    if (sel_ctrl)      oReadData = ctrl_val;
    else if (sel_data) oReadData = data_val;
  end

  always_comb begin
    count_next = count;
    if (push_ok && !pop)      count_next = count + (AW+1)'(1);
    else if (pop && !push_ok) count_next = count - (AW+1)'(1);
  end

  // Overflow set takes priority over a same-cycle W1C clear.
  always_comb begin
    ie_next  = ie;
    ovf_next = ovf;
    if (ctrl_wr) begin
      ie_next = iWriteData[1];
      if (iWriteData[2]) ovf_next = 1'b0;
    end
    if (overflow) ovf_next = 1'b1;
  end

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      ie     <= 1'b0;
      ovf    <= 1'b0;
      oIRQ   <= 1'b0;
    end else begin
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      count <= count_next;
      ie    <= ie_next;
      ovf   <= ovf_next;
      oIRQ  <= ie_next & (count_next != '0);
    end
  end

  // Storage is not reset; an empty count makes stale contents invisible.
  always_ff @(posedge iCLK) begin
    if (push_ok) mem[wr_ptr] <= iKeyData;
  end

endmodule

// File: tb/tb_kbd_mmio_fifo.sv
// ---------------------------------------------------------------------------
// tb_kbd_mmio_fifo
//   Scoreboard bench for kbd_mmio_fifo. The driver issues one bus/keyboard
//   transaction per cycle (inputs change 1 ns after the rising edge), computes
//   the expected read data, hit flag and IRQ from a queue-based reference
//   model and pushes them into a scoreboard. The monitor pops one entry at each
//   falling edge and compares it with the DUT outputs.
// ---------------------------------------------------------------------------
module tb_kbd_mmio_fifo;

  localparam logic [31:0] BASE  = 32'hFF20_0000;
  localparam logic [31:0] DADDR = 32'hFF20_0004;
  localparam int          DEPTH = 16;

  logic        iCLK;
  logic        iRST;
  logic [7:0]  iKeyData;
  logic        iKeyValid;
  logic        iReadEnable;
  logic        iWriteEnable;
  logic [3:0]  iByteEnable;
  logic [31:0] iAddress;
  logic [31:0] iWriteData;
  logic [31:0] oReadData;
  logic        oHit;
  logic        oIRQ;

  kbd_mmio_fifo #(.BASE_ADDR(BASE), .DEPTH(DEPTH), .AW(4)) dut (
    .iCLK(iCLK), .iRST(iRST), .iKeyData(iKeyData), .iKeyValid(iKeyValid),
    .iReadEnable(iReadEnable), .iWriteEnable(iWriteEnable),
    .iByteEnable(iByteEnable), .iAddress(iAddress), .iWriteData(iWriteData),
    .oReadData(oReadData), .oHit(oHit), .oIRQ(oIRQ)
  );

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  typedef struct {
    bit          chk_rd;
    logic [31:0] data;
    bit          hit;
    bit          irq;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;

  // Reference model: FIFO as a byte queue plus the two control flags.
  byte unsigned mq[$];
  bit           m_ie;
  bit           m_ovf;
  bit           m_irq;

  function automatic void m_reset();
    mq.delete();
    m_ie  = 1'b0;
    m_ovf = 1'b0;
    m_irq = 1'b0;
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a);
    logic [31:0] v;
    v = 32'h0;
    if (a == BASE)
      v = (32'(mq.size()) << 8) | (m_ovf ? 32'h4 : 32'h0) |
          (m_ie ? 32'h2 : 32'h0) | ((mq.size() != 0) ? 32'h1 : 32'h0);
    else if (a == DADDR && mq.size() != 0)
      v = {24'h0, mq[0]};
    return v;
  endfunction

  task automatic step(input bit kv, input logic [7:0] kd, input bit re,
                      input bit we, input logic [3:0] be,
                      input logic [31:0] a, input logic [31:0] wd);
    exp_t e;
    bit   do_pop;
    iKeyValid    = kv;
    iKeyData     = kd;
    iReadEnable  = re;
    iWriteEnable = we;
    iByteEnable  = be;
    iAddress     = a;
    iWriteData   = wd;
    if (!iRST) m_reset();
    e.chk_rd = re;
    e.data   = m_read(a);
    e.hit    = (a == BASE) || (a == DADDR);
    e.irq    = m_irq;
    e.cyc    = cyc;
    sb.push_back(e);
    if (iRST) begin
      do_pop = re && (a == DADDR) && (mq.size() != 0);
      if (we && a == BASE && be[0]) begin
        m_ie = wd[1];
        if (wd[2]) m_ovf = 1'b0;
      end
      if (do_pop) void'(mq.pop_front());
      if (kv) begin
        if (mq.size() < DEPTH) mq.push_back(kd);
        else m_ovf = 1'b1;
      end
      m_irq = m_ie && (mq.size() != 0);
    end
    @(posedge iCLK);
    #1;
    cyc++;
  endtask

  task automatic idle();
    step(1'b0, 8'h00, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  task automatic rd(input logic [31:0] a);
    step(1'b0, 8'h00, 1'b1, 1'b0, 4'h0, a, 32'h0);
  endtask

  task automatic push(input logic [7:0] b);
    step(1'b1, b, 1'b0, 1'b0, 4'h0, BASE, 32'h0);
  endtask

  task automatic wr_ctrl(input logic [31:0] d, input logic [3:0] be);
    step(1'b0, 8'h00, 1'b0, 1'b1, be, BASE, d);
  endtask

  // Reset asserted between clock edges while CTRL is being read.
  task automatic async_reset();
    exp_t e;
    iKeyValid    = 1'b0;
    iReadEnable  = 1'b1;
    iWriteEnable = 1'b0;
    iAddress     = BASE;
    #2;
    iRST = 1'b0;
    m_reset();
    e.chk_rd = 1'b1;
    e.data   = 32'h0;
    e.hit    = 1'b1;
    e.irq    = 1'b0;
    e.cyc    = cyc;
    sb.push_back(e);
    @(posedge iCLK);
    #1;
    cyc++;
  endtask

  always @(negedge iCLK) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.chk_rd) begin
        tests++;
        if (oReadData !== e.data) begin
          fails++;
          $display("FAIL rdata cyc=%0d addr=%h got=%h exp=%h", e.cyc, iAddress, oReadData, e.data);
        end
        tests++;
        if (oHit !== e.hit) begin
          fails++;
          $display("FAIL hit cyc=%0d addr=%h got=%b exp=%b", e.cyc, iAddress, oHit, e.hit);
        end
      end
      tests++;
      if (oIRQ !== e.irq) begin
        fails++;
        $display("FAIL irq cyc=%0d got=%b exp=%b", e.cyc, oIRQ, e.irq);
      end
    end
  end

  initial begin
    iRST = 1'b1; iKeyData = '0; iKeyValid = 1'b0; iReadEnable = 1'b0;
    iWriteEnable = 1'b0; iByteEnable = '0; iAddress = '0; iWriteData = '0;
    m_reset();
    #1 iRST = 1'b0;
    @(posedge iCLK);
    #1;
    // Reads while held in reset, then after release.
    rd(BASE);
    rd(DADDR);
    iRST = 1'b1;
    rd(BASE);
    rd(DADDR);
    rd(BASE + 32'd8);

    // Three pushes, status, in-order drain.
    push(8'h41); push(8'h42); push(8'h43);
    rd(BASE);
    rd(DADDR); rd(DADDR); rd(DADDR);
    rd(BASE);

    // Interrupt rise and fall around one byte.
    wr_ctrl(32'h2, 4'b0001);
    push(8'h5A);
    idle();
    rd(DADDR);
    idle();
    rd(BASE);

    // Write with lane 0 disabled is ignored; then disable IE.
    wr_ctrl(32'h0, 4'b1110);
    rd(BASE);
    wr_ctrl(32'h0, 4'b0001);

    // Fill, overflow, clear OVF, push+pop at full, drain.
    for (int i = 0; i < DEPTH; i++) push(8'(i));
    push(8'hFF);
    rd(BASE);
    wr_ctrl(32'h4, 4'b0001);
    rd(BASE);
    step(1'b1, 8'h77, 1'b1, 1'b0, 4'h0, DADDR, 32'h0);
    rd(BASE);
    step(1'b0, 8'h00, 1'b1, 1'b1, 4'hF, DADDR, 32'hFFFF_FFFF);  // DATA write ignored
    for (int i = 0; i < DEPTH - 1; i++) rd(DADDR);
    rd(BASE);

    // Push into empty while DATA is read.
    step(1'b1, 8'h99, 1'b1, 1'b0, 4'h0, DADDR, 32'h0);
    rd(DADDR);
    rd(DADDR);

    // Overflow set and W1C in the same cycle: set wins.
    for (int i = 0; i < DEPTH; i++) push(8'(8'hA0 + i));
    step(1'b1, 8'hEE, 1'b0, 1'b1, 4'h1, BASE, 32'h4);
    rd(BASE);

    // Randomized traffic, alternating push-heavy and pop-heavy phases.
    for (int i = 0; i < 400; i++) begin
      logic [31:0] a;
      bit          heavy;
      bit          kv;
      bit          re;
      bit          we;
      heavy = ((i / 50) % 2) == 0;
      case ($urandom_range(0, 7))
        0, 1:       a = BASE;
        2, 3, 4, 5: a = DADDR;
        6:          a = BASE + 32'd8;
        default:    a = $urandom;
      endcase
      kv = $urandom_range(0, 99) < (heavy ? 80 : 30);
      re = $urandom_range(0, 99) < (heavy ? 30 : 80);
      we = $urandom_range(0, 7) == 0;
      step(kv, 8'($urandom), re, we, 4'($urandom), a, $urandom);
    end

    // Streaming push/pop across pointer wrap, then asynchronous reset.
    wr_ctrl(32'h6, 4'b0001);
    push(8'h10); push(8'h11); push(8'h12);
    for (int i = 0; i < 20; i++) step(1'b1, 8'($urandom), 1'b1, 1'b0, 4'h0, DADDR, 32'h0);
    async_reset();
    rd(DADDR);
    iRST = 1'b1;
    push(8'h33);
    rd(BASE);
    rd(DADDR);
    rd(BASE);
    idle();

    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain got=%0d exp=0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
